// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control bundle between the multi-cycle FSM and the RV32 datapath.
interface multicycle_controller_if #(parameter int CNT_W = 32);
    logic [6:0]       Opcode;
    logic             mem_ready;
    logic             BrTaken;
    logic             IMemRead;
    logic             IRWrite;
    logic             PCWrite;
    logic             ALUSrc;
    logic             MemtoReg;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic [1:0]       ALUOp;
    logic             Branch;
    logic             Jal;
    logic             Jalr;
    logic             Halt;
    logic             Illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;
    modport master (
        input  Opcode, mem_ready, BrTaken,
        output IMemRead, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
               ALUOp, Branch, Jal, Jalr, Halt, Illegal, state, instret
    );
    modport slave (
        output Opcode, mem_ready, BrTaken,
        input  IMemRead, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
               ALUOp, Branch, Jal, Jalr, Halt, Illegal, state, instret
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB control FSM with memory-wait timeout and retire counter.
module multicycle_controller #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master bus
);
    localparam int WW = MEM_WAIT_MAX > 0 ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_U    = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_HALT = 7'b0000001;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALTED, ERROR} state_t;

    state_t           state, state_n;
    logic [6:0]       op_q;
    logic [WW-1:0]    wait_cnt;
    logic [CNT_W-1:0] instret;
    logic             is_r, is_lw, is_sw, is_br, is_i, is_u, is_jal, is_jalr;
    logic             legal_in, timeout;

    assign is_r    = op_q == OP_R;
    assign is_lw   = op_q == OP_LW;
    assign is_sw   = op_q == OP_SW;
    assign is_br   = op_q == OP_BR;
    assign is_i    = op_q == OP_I;
    assign is_u    = op_q == OP_U;
    assign is_jal  = op_q == OP_JAL;
    assign is_jalr = op_q == OP_JALR;

    // DECODE classifies the live Opcode; later states use the latched op_q
    assign legal_in = bus.Opcode inside {OP_R, OP_LW, OP_SW, OP_BR, OP_I, OP_U, OP_JAL, OP_JALR};
    assign timeout  = MEM_WAIT_MAX != 0 && wait_cnt == WW'(MEM_WAIT_MAX) && !bus.mem_ready;

    assign bus.state   = state;
    assign bus.instret = instret;

    always_comb begin
        state_n      = state;
        bus.IMemRead = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.ALUSrc   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.RegWrite = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.ALUOp    = 2'b00;
        bus.Branch   = 1'b0;
        bus.Jal      = 1'b0;
        bus.Jalr     = 1'b0;
        bus.Halt     = 1'b0;
        bus.Illegal  = 1'b0;
        case (state)
            FETCH: begin
                bus.IMemRead = 1'b1;
                bus.IRWrite  = bus.mem_ready;
                state_n      = bus.mem_ready ? DECODE : timeout ? ERROR : FETCH;
            end
            DECODE: state_n = bus.Opcode == OP_HALT ? HALTED : legal_in ? EXEC : ERROR;
            EXEC: begin
                bus.ALUSrc  = is_lw | is_sw | is_i | is_u | is_jalr;
                bus.ALUOp   = is_br ? 2'b01 : (is_r | is_i | is_jalr) ? 2'b10 : is_u ? 2'b11 : 2'b00;
                bus.Branch  = is_br & bus.BrTaken;
                bus.PCWrite = is_br;
                state_n     = is_br ? FETCH : (is_lw | is_sw) ? MEM : WB;
            end
            MEM: begin
                bus.ALUSrc   = 1'b1;
                bus.MemRead  = is_lw;
                bus.MemWrite = is_sw;
                bus.PCWrite  = is_sw & bus.mem_ready;
                state_n      = bus.mem_ready ? (is_sw ? FETCH : WB) : timeout ? ERROR : MEM;
            end
            WB: begin
                bus.RegWrite = 1'b1;
                bus.PCWrite  = 1'b1;
                bus.MemtoReg = is_lw;
                bus.Jal      = is_jal;
                bus.Jalr     = is_jalr;
                bus.ALUSrc   = is_jalr;
                bus.ALUOp    = is_jalr ? 2'b10 : 2'b00;
                state_n      = FETCH;
            end
            HALTED: bus.Halt = 1'b1;
            ERROR:  bus.Illegal = 1'b1;
            default: state_n = ERROR;
        endcase
    end

    // wait_cnt only advances while FETCH/MEM stalls; any transition restarts it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
            instret  <= '0;
        end else begin
            state    <= state_n;
            op_q     <= state == DECODE ? bus.Opcode : op_q;
            wait_cnt <= (state_n == state && (state == FETCH || state == MEM)) ? wait_cnt + 1'b1 : '0;
            instret  <= bus.PCWrite ? instret + 1'b1 : instret;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: instruction-level reference model driving randomized programs and memory stalls.
module tb_multicycle_controller;
    localparam logic [6:0] R    = 7'b0110011;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] I    = 7'b0010011;
    localparam logic [6:0] U    = 7'b0110111;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] HLT  = 7'b0000001;
    localparam int B_IMR = 14, B_IRW = 13, B_PCW = 12, B_ALS = 11, B_M2R = 10, B_RW = 9;
    localparam int B_MRD = 8, B_MWR = 7, B_BR = 4, B_JAL = 3, B_JALR = 2, B_HLT = 1, B_ILL = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int fails = 0;
    logic        exp_valid = 1'b0;
    logic [2:0]  exp_state = 3'd0;
    logic [14:0] exp_ctrl = '0;
    logic [31:0] m_ret = 0;
    logic [14:0] act_ctrl;
    logic [6:0]  legal_ops [8] = '{R, LW, SW, BR, I, U, JAL, JALR};
    logic [6:0]  bad_ops [4] = '{7'h7F, 7'h00, 7'b0110001, 7'b1100010};

    multicycle_controller_if #(.CNT_W(32)) bus();
    multicycle_controller #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    assign act_ctrl = {bus.IMemRead, bus.IRWrite, bus.PCWrite, bus.ALUSrc, bus.MemtoReg, bus.RegWrite,
                       bus.MemRead, bus.MemWrite, bus.ALUOp, bus.Branch, bus.Jal, bus.Jalr, bus.Halt, bus.Illegal};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (exp_valid) begin
        check("state", 32'(bus.state), 32'(exp_state));
        check("ctrl", 32'(act_ctrl), 32'(exp_ctrl));
        check("instret", bus.instret, m_ret);
    end

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    // one clock of stimulus with the outputs the model expects for it; a PCWrite cycle retires
    task automatic step(input logic mr, input logic bt, input logic [6:0] op, input logic [2:0] st, input logic [14:0] c);
        bus.mem_ready = mr;
        bus.BrTaken   = bt;
        bus.Opcode    = op;
        exp_state     = st;
        exp_ctrl      = c;
        exp_valid     = 1'b1;
        @(posedge clk);
        #1;
        if (c[B_PCW]) m_ret++;
    endtask

    task automatic do_reset();
        logic [14:0] c;
        reset = 1'b1;
        m_ret = 0;
        c = '0;
        c[B_IMR] = 1'b1;
        step(1'b0, rb(), rop(), 3'd0, c);
        reset = 1'b0;
    endtask

    // fw/mw: stall cycles before mem_ready in FETCH/MEM; more than 15 means the access never completes
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic bt,
                             output int cyc, output int fin);
        logic [14:0] c;
        logic mr, lw, sw;
        cyc = 0;
        fin = 0;
        lw = op == LW;
        sw = op == SW;
        for (int k = 0; k <= fw && k <= 15; k++) begin
            mr = k == fw;
            c = '0;
            c[B_IMR] = 1'b1;
            c[B_IRW] = mr;
            step(mr, rb(), rop(), 3'd0, c);
            cyc++;
        end
        if (fw > 15) begin fin = 6; return; end
        c = '0;
        step(rb(), rb(), op, 3'd1, c);
        cyc++;
        if (op == HLT) begin fin = 5; return; end
        if (!(op inside {R, LW, SW, BR, I, U, JAL, JALR})) begin fin = 6; return; end
        c = '0;
        c[B_ALS] = op inside {LW, SW, I, U, JALR};
        c[6:5] = op == BR ? 2'b01 : op inside {R, I, JALR} ? 2'b10 : op == U ? 2'b11 : 2'b00;
        c[B_BR] = op == BR && bt;
        c[B_PCW] = op == BR;
        step(rb(), op == BR ? bt : rb(), rop(), 3'd2, c);
        cyc++;
        if (op == BR) return;
        if (lw || sw) begin
            for (int k = 0; k <= mw && k <= 15; k++) begin
                mr = k == mw;
                c = '0;
                c[B_ALS] = 1'b1;
                c[B_MRD] = lw;
                c[B_MWR] = sw;
                c[B_PCW] = sw && mr;
                step(mr, rb(), rop(), 3'd3, c);
                cyc++;
            end
            if (mw > 15) begin fin = 6; return; end
            if (sw) return;
        end
        c = '0;
        c[B_RW] = 1'b1;
        c[B_PCW] = 1'b1;
        c[B_M2R] = lw;
        c[B_JAL] = op == JAL;
        c[B_JALR] = op == JALR;
        c[B_ALS] = op == JALR;
        c[6:5] = op == JALR ? 2'b10 : 2'b00;
        step(rb(), rb(), rop(), 3'd4, c);
        cyc++;
    endtask

    task automatic terminal(input int n, input int fin);
        logic [14:0] c;
        c = '0;
        c[fin == 5 ? B_HLT : B_ILL] = 1'b1;
        repeat (n) step(rb(), rb(), rop(), 3'(fin), c);
    endtask

    initial begin
        int cyc, fin, r, fw, mw;
        logic [6:0] op;
        logic [14:0] c;
        bus.mem_ready = 1'b0;
        bus.BrTaken   = 1'b0;
        bus.Opcode    = '0;
        do_reset();
        do_reset();
        check("reset_instret", bus.instret, 0);

        run_instr(R, 0, 0, 1'b0, cyc, fin);
        check("r_latency", cyc, 4);
        check("r_instret", bus.instret, 1);
        run_instr(LW, 0, 3, 1'b0, cyc, fin);
        check("lw_latency", cyc, 8);
        run_instr(BR, 0, 0, 1'b1, cyc, fin);
        check("br_taken_latency", cyc, 3);
        run_instr(BR, 0, 0, 1'b0, cyc, fin);
        check("br_not_latency", cyc, 3);
        check("br_instret", bus.instret, 4);
        run_instr(R, 15, 0, 1'b0, cyc, fin);
        check("late_ready_latency", cyc, 19);

        run_instr(R, 16, 0, 1'b0, cyc, fin);
        check("fetch_timeout_cycles", cyc, 16);
        terminal(3, 6);
        check("fetch_timeout_state", 32'(bus.state), 6);
        check("fetch_timeout_illegal", 32'(bus.Illegal), 1);

        do_reset();
        run_instr(R, 0, 0, 1'b0, cyc, fin);
        run_instr(I, 1, 0, 1'b0, cyc, fin);
        run_instr(HLT, 0, 0, 1'b0, cyc, fin);
        check("halt_fin", fin, 5);
        terminal(20, 5);
        check("halt_state", 32'(bus.state), 5);
        check("halt_flag", 32'(bus.Halt), 1);
        check("halt_instret", bus.instret, 2);

        do_reset();
        run_instr(7'h7F, 0, 0, 1'b0, cyc, fin);
        check("illegal_fin", fin, 6);
        terminal(3, 6);
        check("illegal_state", 32'(bus.state), 6);

        do_reset();
        run_instr(SW, 0, 16, 1'b0, cyc, fin);
        check("mem_timeout_cycles", cyc, 19);
        terminal(2, 6);

        // SW aborted by reset while stalled in MEM
        do_reset();
        run_instr(R, 0, 0, 1'b0, cyc, fin);
        c = '0; c[B_IMR] = 1'b1; c[B_IRW] = 1'b1;
        step(1'b1, 1'b0, rop(), 3'd0, c);
        c = '0;
        step(1'b0, 1'b0, SW, 3'd1, c);
        c = '0; c[B_ALS] = 1'b1;
        step(1'b0, 1'b0, rop(), 3'd2, c);
        c = '0; c[B_ALS] = 1'b1; c[B_MWR] = 1'b1;
        bus.mem_ready = 1'b0;
        exp_state = 3'd3;
        exp_ctrl = c;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_memwrite", 32'(bus.MemWrite), 0);
        check("abort_regwrite", 32'(bus.RegWrite), 0);
        check("abort_state", 32'(bus.state), 0);
        check("abort_instret", bus.instret, 0);
        m_ret = 0;
        exp_state = 3'd0;
        c = '0; c[B_IMR] = 1'b1;
        exp_ctrl = c;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(R, 1, 0, 1'b0, cyc, fin);
        check("resume_instret", bus.instret, 1);

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            op = r < 3 ? HLT : r < 6 ? bad_ops[$urandom_range(0, 3)] : legal_ops[$urandom_range(0, 7)];
            fw = $urandom_range(0, 9) == 0 ? $urandom_range(0, 16) : $urandom_range(0, 2);
            mw = $urandom_range(0, 9) == 0 ? $urandom_range(0, 16) : $urandom_range(0, 2);
            run_instr(op, fw, mw, rb(), cyc, fin);
            if (fin != 0) begin
                terminal($urandom_range(1, 4), fin);
                do_reset();
            end
        end
        exp_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
